// File: rtl/pb_port_responder.sv
// KCPSM6 port-mapped responder: 4-entry RX FIFO, single TX holding register,
// sticky overflow/overrun flags and a level interrupt, all behind four I/O ports.
module pb_port_responder #(
   parameter logic [7:0] BASE = 8'h00
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] port_id,
   input  logic [7:0] out_port,
   input  logic       write_strobe,
   input  logic       k_write_strobe,
   input  logic       read_strobe,
   output logic [7:0] in_port,
   input  logic [7:0] rx_data,
   input  logic       rx_strobe,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ack,
   output logic       irq
);

   logic [7:0] fifo_q [4];
   logic [1:0] rd_ptr_q, rd_ptr_d;
   logic [1:0] wr_ptr_q, wr_ptr_d;
   logic [2:0] rx_count_q, rx_count_d;
   logic       rx_ovf_q, rx_ovf_d;
   logic       tx_ovr_q, tx_ovr_d;
   logic [7:0] tx_data_q, tx_data_d;
   logic       tx_valid_q, tx_valid_d;
   logic [7:0] in_port_q, in_port_d;

   logic [3:0] wr_hit;
   logic       rd_fifo_addr;
   logic       pop, push, full, ovf_set, flush;
   logic       ctl_clr_ovf, ctl_clr_ovr;
   logic       tx_wr, tx_take, tx_ovr_set;
   logic [7:0] status;

   // OUTPUTK only carries a 4-bit port address, so it matches on the low nibble.
   always_comb begin
      wr_hit = '0;
      for (int unsigned n = 0; n < 4; n++) begin
         wr_hit[n] = (write_strobe && (port_id == BASE + 8'(n))) ||
                     (k_write_strobe && (port_id[3:0] == BASE[3:0] + 4'(n)));
      end
   end

   always_comb begin
      rd_fifo_addr = (port_id == BASE + 8'd1);
      full         = (rx_count_q == 3'd4);
      pop          = read_strobe && rd_fifo_addr && (rx_count_q != 3'd0);
      push         = rx_strobe && (!full || pop);
      ovf_set      = rx_strobe && full && !pop;
      flush        = wr_hit[3] && out_port[2];
      ctl_clr_ovf  = wr_hit[3] && out_port[0];
      ctl_clr_ovr  = wr_hit[3] && out_port[1];
   end

   always_comb begin
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      rx_count_d = rx_count_q;
      if (flush) begin
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         rx_count_d = '0;
      end else begin
         rd_ptr_d   = rd_ptr_q + {1'b0, pop};
         wr_ptr_d   = wr_ptr_q + {1'b0, push};
         rx_count_d = rx_count_q + {2'b00, push} - {2'b00, pop};
      end
   end

   // Set beats a same-cycle CONTROL clear.
   always_comb begin
      rx_ovf_d = ovf_set    | (rx_ovf_q & ~ctl_clr_ovf);
      tx_ovr_d = tx_ovr_set | (tx_ovr_q & ~ctl_clr_ovr);
   end

   always_comb begin
      tx_wr      = wr_hit[2];
      tx_take    = tx_valid_q && tx_ack;
      tx_ovr_set = tx_wr && tx_valid_q && !tx_ack;
      tx_data_d  = tx_data_q;
      tx_valid_d = tx_valid_q;
      if (tx_wr && (!tx_valid_q || tx_take)) begin
         tx_data_d  = out_port;
         tx_valid_d = 1'b1;
      end else if (tx_take) begin
         tx_valid_d = 1'b0;
      end
   end

   always_comb begin
      status    = {2'b00, rx_count_q, tx_valid_q, rx_ovf_q, tx_ovr_q};
      in_port_d = '0;
      if (port_id[7:2] == BASE[7:2]) begin
         case (port_id[1:0])
            2'd0:    in_port_d = status;
            2'd1:    in_port_d = (rx_count_q != 3'd0) ? fifo_q[rd_ptr_q] : '0;
            default: in_port_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < 4; i++) begin
            fifo_q[i] <= '0;
         end
      end else if (push && !flush) begin
         fifo_q[wr_ptr_q] <= rx_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         rx_count_q <= '0;
         rx_ovf_q   <= 1'b0;
         tx_ovr_q   <= 1'b0;
         tx_data_q  <= '0;
         tx_valid_q <= 1'b0;
         in_port_q  <= '0;
      end else begin
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         rx_count_q <= rx_count_d;
         rx_ovf_q   <= rx_ovf_d;
         tx_ovr_q   <= tx_ovr_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
         in_port_q  <= in_port_d;
      end
   end

   assign in_port  = in_port_q;
   assign tx_data  = tx_data_q;
   assign tx_valid = tx_valid_q;
   assign irq      = (rx_count_q != 3'd0) | rx_ovf_q | tx_ovr_q;

endmodule

// File: tb/tb_pb_port_responder.sv
// Directed bench for pb_port_responder: queue-based reference model compared every
// cycle, plus literal expectations at the key points of each scenario.
module tb_pb_port_responder;

   localparam logic [7:0] BASE = 8'h40;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] port_id = '0;
   logic [7:0] out_port = '0;
   logic       write_strobe = 1'b0;
   logic       k_write_strobe = 1'b0;
   logic       read_strobe = 1'b0;
   logic [7:0] in_port;
   logic [7:0] rx_data = '0;
   logic       rx_strobe = 1'b0;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ack = 1'b0;
   logic       irq;

   int tests = 0;
   int fails = 0;

   pb_port_responder #(.BASE(BASE)) dut (
      .clk(clk), .reset(reset), .port_id(port_id), .out_port(out_port),
      .write_strobe(write_strobe), .k_write_strobe(k_write_strobe),
      .read_strobe(read_strobe), .in_port(in_port), .rx_data(rx_data),
      .rx_strobe(rx_strobe), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ack(tx_ack), .irq(irq)
   );

   initial forever #5 clk = ~clk;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at %0t: got %02h, expected %02h", name, $time, act, exp);
      end
   endtask

   // Reference model: FIFO as a queue, flags as plain bits.
   logic [7:0] m_q[$];
   logic [7:0] m_in = '0, m_txd = '0;
   logic       m_txv = 1'b0, m_ovf = 1'b0, m_ovr = 1'b0;

   initial begin
      logic [7:0] nxt;
      logic       w2, w3;
      forever begin
         @(posedge clk or negedge reset);
         if (!reset) begin
            m_q.delete();
            m_in = '0; m_txd = '0; m_txv = 1'b0; m_ovf = 1'b0; m_ovr = 1'b0;
         end else begin
            nxt = '0;
            if (port_id == BASE)
               nxt = {2'b00, 3'(m_q.size()), m_txv, m_ovf, m_ovr};
            else if (port_id == BASE + 8'd1 && m_q.size() > 0)
               nxt = m_q[0];
            w2 = (write_strobe && port_id == BASE + 8'd2) ||
                 (k_write_strobe && port_id[3:0] == BASE[3:0] + 4'd2);
            w3 = (write_strobe && port_id == BASE + 8'd3) ||
                 (k_write_strobe && port_id[3:0] == BASE[3:0] + 4'd3);
            if (w3 && out_port[0]) m_ovf = 1'b0;
            if (w3 && out_port[1]) m_ovr = 1'b0;
            if (read_strobe && port_id == BASE + 8'd1 && m_q.size() > 0)
               void'(m_q.pop_front());
            if (rx_strobe) begin
               if (m_q.size() < 4) m_q.push_back(rx_data);
               else m_ovf = 1'b1;
            end
            if (m_txv && tx_ack) m_txv = 1'b0;
            if (w2) begin
               if (!m_txv) begin m_txd = out_port; m_txv = 1'b1; end
               else m_ovr = 1'b1;
            end
            if (w3 && out_port[2]) m_q.delete();
            m_in = nxt;
         end
      end
   end

   initial forever begin
      @(negedge clk);
      chk("cyc in_port", in_port, m_in);
      chk("cyc tx_data", tx_data, m_txd);
      chk("cyc tx_valid", {7'b0, tx_valid}, {7'b0, m_txv});
      chk("cyc irq", {7'b0, irq}, {7'b0, (m_q.size() > 0) || m_ovf || m_ovr});
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] b);
      rx_data = b; rx_strobe = 1'b1; tick(); rx_strobe = 1'b0;
   endtask

   task automatic rd(input logic [7:0] a);
      port_id = a; read_strobe = 1'b1; tick(); read_strobe = 1'b0;
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d, input logic k);
      port_id = a; out_port = d;
      if (k) k_write_strobe = 1'b1; else write_strobe = 1'b1;
      tick();
      write_strobe = 1'b0; k_write_strobe = 1'b0;
   endtask

   task automatic status(input string name, input logic [7:0] exp);
      port_id = BASE; tick(); chk(name, in_port, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("reset in_port", in_port, 8'h00);
      chk("reset tx_data", tx_data, 8'h00);
      chk("reset tx_valid", {7'b0, tx_valid}, 8'h00);
      chk("reset irq", {7'b0, irq}, 8'h00);
      @(negedge clk); reset = 1'b1;

      // basic push/pop
      push(8'hA1); push(8'hB2);
      rd(BASE + 8'd1); chk("pop1", in_port, 8'hA1);
      rd(BASE + 8'd1); chk("pop2", in_port, 8'hB2);
      status("status empty", 8'h00);
      chk("irq empty", {7'b0, irq}, 8'h00);

      // overflow
      for (int i = 1; i <= 5; i++) push(8'(i));
      status("status ovf", 8'h22);
      chk("irq ovf", {7'b0, irq}, 8'h01);
      for (int i = 1; i <= 4; i++) begin
         rd(BASE + 8'd1); chk("ovf read", in_port, 8'(i));
      end
      status("status ovf drained", 8'h02);
      wr(BASE + 8'd3, 8'h01, 1'b0);
      status("status ovf cleared", 8'h00);

      // overflow set wins over same-cycle clear, then flush+clear
      for (int i = 0; i < 4; i++) push(8'hC1 + 8'(i));
      rx_data = 8'hC5; rx_strobe = 1'b1;
      port_id = BASE + 8'd3; out_port = 8'h01; write_strobe = 1'b1;
      tick();
      rx_strobe = 1'b0; write_strobe = 1'b0;
      status("set wins", 8'h22);
      wr(BASE + 8'd3, 8'h05, 1'b0);
      status("flush+clear", 8'h00);

      // full FIFO with simultaneous push and pop
      for (int i = 1; i <= 4; i++) push(8'h11 * 8'(i));
      rx_data = 8'h55; rx_strobe = 1'b1;
      port_id = BASE + 8'd1; read_strobe = 1'b1;
      tick();
      rx_strobe = 1'b0; read_strobe = 1'b0;
      chk("full pushpop head", in_port, 8'h11);
      status("full pushpop status", 8'h20);
      rd(BASE + 8'd1); chk("fp r1", in_port, 8'h22);
      rd(BASE + 8'd1); chk("fp r2", in_port, 8'h33);
      rd(BASE + 8'd1); chk("fp r3", in_port, 8'h44);
      rd(BASE + 8'd1); chk("fp r4", in_port, 8'h55);

      // TX path
      wr(BASE + 8'd2, 8'h3C, 1'b0);
      chk("tx load", tx_data, 8'h3C);
      chk("tx valid", {7'b0, tx_valid}, 8'h01);
      wr(8'h02, 8'hEE, 1'b0);
      status("unmapped OUTPUT ignored", 8'h04);
      wr(8'h02, 8'h7E, 1'b1);
      chk("tx overrun data", tx_data, 8'h3C);
      status("tx overrun status", 8'h05);
      tx_ack = 1'b1;
      wr(BASE + 8'd2, 8'h99, 1'b0);
      tx_ack = 1'b0;
      chk("tx ack+write data", tx_data, 8'h99);
      chk("tx ack+write valid", {7'b0, tx_valid}, 8'h01);
      status("tx ack+write status", 8'h05);
      wr(BASE + 8'd3, 8'h02, 1'b0);
      status("tx ovr cleared", 8'h04);
      tx_ack = 1'b1; tick();
      chk("tx consumed", {7'b0, tx_valid}, 8'h00);
      tick(); tx_ack = 1'b0;
      status("tx ack idle ignored", 8'h00);

      // unmapped reads, writes to read-only ports
      port_id = BASE + 8'd4; tick(); chk("unmapped read", in_port, 8'h00);
      port_id = BASE + 8'd2; tick(); chk("write-only read", in_port, 8'h00);
      wr(BASE, 8'hFF, 1'b0); wr(BASE + 8'd1, 8'hFF, 1'b0);
      status("ro writes ignored", 8'h00);

      // flush beats same-cycle push
      push(8'hD1); push(8'hD2); push(8'hD3);
      rx_data = 8'hD4; rx_strobe = 1'b1;
      port_id = BASE + 8'd3; out_port = 8'h04; write_strobe = 1'b1;
      tick();
      rx_strobe = 1'b0; write_strobe = 1'b0;
      port_id = BASE + 8'd1; tick(); chk("flush head", in_port, 8'h00);
      status("flush status", 8'h00);
      chk("flush irq", {7'b0, irq}, 8'h00);

      // asynchronous reset mid-operation
      push(8'hE1); push(8'hE2);
      wr(BASE + 8'd2, 8'h5A, 1'b0);
      port_id = BASE;
      @(posedge clk); #2;
      reset = 1'b0; #1;
      chk("async in_port", in_port, 8'h00);
      chk("async tx_data", tx_data, 8'h00);
      chk("async tx_valid", {7'b0, tx_valid}, 8'h00);
      chk("async irq", {7'b0, irq}, 8'h00);
      @(posedge clk); @(negedge clk); reset = 1'b1;
      status("post-reset status", 8'h00);
      port_id = BASE + 8'd1; tick(); chk("post-reset head", in_port, 8'h00);

      tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
